// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Function : ID/EX pipeline register with ALU-control decode, immediate
//            extension and EX/MEM / MEM/WB operand forwarding for the ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm16,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [AW-1:0] id_rd_addr,
  input  logic [5:0]    id_funct,
  input  logic [1:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_branch,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] In1,
  output logic [DW-1:0] In2,
  output logic [3:0]    ALUCtr,
  output logic          ex_valid,
  output logic [DW-1:0] ex_store_data,
  output logic [AW-1:0] ex_wr_addr,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_branch,
  output logic          ex_illegal
);

  // Stage registers
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] imm_ext;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          alu_src;

  // Values prepared for the next load
  logic [3:0]    alu_ctr_d;
  logic          funct_ok;
  logic          illegal_d;
  logic [DW-1:0] imm_d;

  // Forwarded operands
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  // ALU-control decode and immediate extension of the incoming ID fields
  always_comb begin
    alu_ctr_d = 4'd2;
    funct_ok  = 1'b1;
    case (id_alu_op)
      2'b00: alu_ctr_d = 4'd2;
      2'b01: alu_ctr_d = 4'd6;
      2'b11: alu_ctr_d = 4'd1;
      default: begin
        case (id_funct)
          6'b100000: alu_ctr_d = 4'd2;
          6'b100010: alu_ctr_d = 4'd6;
          6'b100100: alu_ctr_d = 4'd0;
          6'b100101: alu_ctr_d = 4'd1;
          6'b101010: alu_ctr_d = 4'd7;
          default: begin
            alu_ctr_d = 4'd2;
            funct_ok  = 1'b0;
          end
        endcase
      end
    endcase
    illegal_d = id_valid_i & (id_alu_op == 2'b10) & ~funct_ok;
    // ORI-class (alu_op 11) uses a zero-extended immediate, all others sign-extend
    imm_d = (id_alu_op == 2'b11) ? {{(DW-16){1'b0}}, id_imm16}
                                 : {{(DW-16){id_imm16[15]}}, id_imm16};
  end

  // Stage register update: flush inserts a bubble, stall holds, otherwise load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_wr_addr    <= '0;
      ALUCtr        <= 4'd0;
      ex_illegal    <= 1'b0;
      rs_data       <= '0;
      rt_data       <= '0;
      imm_ext       <= '0;
      rs_addr       <= '0;
      rt_addr       <= '0;
      alu_src       <= 1'b0;
    end else if (flush_i) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_wr_addr    <= '0;
      ALUCtr        <= 4'd0;
      ex_illegal    <= 1'b0;
      rs_data       <= '0;
      rt_data       <= '0;
      imm_ext       <= '0;
      rs_addr       <= '0;
      rt_addr       <= '0;
      alu_src       <= 1'b0;
    end else if (!stall_i) begin
      ex_valid      <= id_valid_i;
      ex_reg_write  <= id_reg_write  & id_valid_i;
      ex_mem_read   <= id_mem_read   & id_valid_i;
      ex_mem_write  <= id_mem_write  & id_valid_i;
      ex_mem_to_reg <= id_mem_to_reg & id_valid_i;
      ex_branch     <= id_branch     & id_valid_i;
      ex_wr_addr    <= id_reg_dst ? id_rd_addr : id_rt_addr;
      ALUCtr        <= alu_ctr_d;
      ex_illegal    <= illegal_d;
      rs_data       <= id_rs_data;
      rt_data       <= id_rt_data;
      imm_ext       <= imm_d;
      rs_addr       <= id_rs_addr;
      rt_addr       <= id_rt_addr;
      alu_src       <= id_alu_src;
    end
  end

  // Operand forwarding: the younger EX/MEM result beats MEM/WB; register 0 never forwards
  always_comb begin
    op_a = rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr)) begin
      op_a = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
      op_a = memwb_result;
    end
    op_b = rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_addr)) begin
      op_b = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_addr)) begin
      op_b = memwb_result;
    end
  end

  assign In1           = op_a;
  assign In2           = alu_src ? imm_ext : op_b;
  assign ex_store_data = op_b;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Function : Scoreboard bench for id_ex_stage with directed and random stimulus
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, id_valid_i;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm16;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] In1, In2, ex_store_data;
  logic [3:0]  ALUCtr;
  logic        ex_valid, ex_illegal;
  logic [4:0]  ex_wr_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm16(id_imm16), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .id_funct(id_funct), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .In1(In1), .In2(In2), .ALUCtr(ALUCtr), .ex_valid(ex_valid),
    .ex_store_data(ex_store_data), .ex_wr_addr(ex_wr_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [1:0]  op;
    logic        src, dst, rw, mr, mw, m2r, br;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } stim_t;

  // What the EX stage currently holds, in instruction terms
  typedef struct {
    logic        valid;
    logic        rw, mr, mw, m2r, br;
    logic        src;
    logic [4:0]  rs, rt, wr;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  ctr;
    logic        ill;
  } ex_t;

  typedef struct {
    logic [95:0] ops;
    logic [15:0] ctl;
  } exp_t;

  ex_t  model;
  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  logic [95:0] ops_act;
  logic [15:0] ctl_act;
  assign ops_act = {In1, In2, ex_store_data};
  assign ctl_act = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                    ex_branch, ex_wr_addr, ALUCtr, ex_illegal};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic ex_t empty_ex();
    ex_t e;
    e.valid = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.br = 0; e.src = 0;
    e.rs = 0; e.rt = 0; e.wr = 0; e.rsd = 0; e.rtd = 0; e.imm = 0; e.ctr = 0; e.ill = 0;
    return e;
  endfunction

  // Reference decode table for the ALU function
  function automatic logic [4:0] alu_of(input logic [1:0] op, input logic [5:0] funct);
    // returns {illegal_funct, ctr}
    if (op == 2'd0) return {1'b0, 4'd2};
    if (op == 2'd1) return {1'b0, 4'd6};
    if (op == 2'd3) return {1'b0, 4'd1};
    if (funct == 6'h20) return {1'b0, 4'd2};
    if (funct == 6'h22) return {1'b0, 4'd6};
    if (funct == 6'h24) return {1'b0, 4'd0};
    if (funct == 6'h25) return {1'b0, 4'd1};
    if (funct == 6'h2A) return {1'b0, 4'd7};
    return {1'b1, 4'd2};
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] own,
                                          input stim_t s);
    if (r == 0) return own;
    if (s.xw && s.xrd == r) return s.xres;
    if (s.ww && s.wrd == r) return s.wres;
    return own;
  endfunction

  function automatic stim_t base_stim();
    stim_t s;
    s.stall = 0; s.flush = 0; s.valid = 1;
    s.rsd = 0; s.rtd = 0; s.imm = 0; s.rs = 1; s.rt = 2; s.rd = 3;
    s.funct = 6'h20; s.op = 2'b10; s.src = 0; s.dst = 1;
    s.rw = 1; s.mr = 0; s.mw = 0; s.m2r = 0; s.br = 0;
    s.xw = 0; s.xrd = 0; s.xres = 0; s.ww = 0; s.wrd = 0; s.wres = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [5:0] legal [5];
    legal[0] = 6'h20; legal[1] = 6'h22; legal[2] = 6'h24; legal[3] = 6'h25; legal[4] = 6'h2A;
    s.stall = ($urandom_range(0, 4) == 0);
    s.flush = ($urandom_range(0, 9) == 0);
    s.valid = ($urandom_range(0, 5) != 0);
    s.rsd = $urandom; s.rtd = $urandom; s.imm = 16'($urandom);
    s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
    s.rd = 5'($urandom_range(0, 31));
    s.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 4)];
    s.op = 2'($urandom); s.src = 1'($urandom); s.dst = 1'($urandom);
    s.rw = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
    s.m2r = 1'($urandom); s.br = 1'($urandom);
    s.xw = 1'($urandom); s.xrd = 5'($urandom_range(0, 7)); s.xres = $urandom;
    s.ww = 1'($urandom); s.wrd = 5'($urandom_range(0, 7)); s.wres = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    stall_i = s.stall; flush_i = s.flush; id_valid_i = s.valid;
    id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm16 = s.imm;
    id_rs_addr = s.rs; id_rt_addr = s.rt; id_rd_addr = s.rd;
    id_funct = s.funct; id_alu_op = s.op; id_alu_src = s.src; id_reg_dst = s.dst;
    id_reg_write = s.rw; id_mem_read = s.mr; id_mem_write = s.mw;
    id_mem_to_reg = s.m2r; id_branch = s.br;
    exmem_reg_write = s.xw; exmem_rd = s.xrd; exmem_result = s.xres;
    memwb_reg_write = s.ww; memwb_rd = s.wrd; memwb_result = s.wres;
  endtask

  // Present one cycle of stimulus and queue what EX must show after the next edge
  task automatic issue(input stim_t s);
    logic [4:0]  dec;
    logic [31:0] a, b;
    exp_t        e;
    @(negedge clk);
    drive(s);
    if (s.flush) begin
      model = empty_ex();
    end else if (!s.stall) begin
      dec         = alu_of(s.op, s.funct);
      model.valid = s.valid;
      model.rw    = s.rw & s.valid;  model.mr = s.mr & s.valid;
      model.mw    = s.mw & s.valid;  model.m2r = s.m2r & s.valid;
      model.br    = s.br & s.valid;
      model.src   = s.src;
      model.rs    = s.rs;  model.rt = s.rt;
      model.wr    = s.dst ? s.rd : s.rt;
      model.rsd   = s.rsd; model.rtd = s.rtd;
      model.imm   = (s.op == 2'b11) ? {16'h0000, s.imm} : {{16{s.imm[15]}}, s.imm};
      model.ctr   = dec[3:0];
      model.ill   = dec[4] & s.valid & (s.op == 2'b10);
    end
    a = operand(model.rs, model.rsd, s);
    b = operand(model.rt, model.rtd, s);
    e.ops = {a, model.src ? model.imm : b, b};
    e.ctl = {model.valid, model.rw, model.mr, model.mw, model.m2r, model.br,
             model.wr, model.ctr, model.ill};
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs shortly after each edge that follows queued stimulus
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("operands", 128'(ops_act), 128'(e.ops));
      chk("control", 128'(ctl_act), 128'(e.ctl));
    end
  end

  initial begin
    stim_t s;
    model = empty_ex();

    // Reset with random inputs: every output must read zero
    rst_n = 1'b0;
    drive(rand_stim());
    #23;
    chk("reset_ops", 128'(ops_act), 128'd0);
    chk("reset_ctl", 128'(ctl_act), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_ctl", 128'(ctl_act), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First load after reset: ADD with rs=4, rt=8
    s = base_stim(); s.rsd = 4; s.rtd = 8;
    issue(s);
    // Decode sweep, then an unsupported funct, then the same as a non-valid slot
    s.funct = 6'h24; issue(s);
    s.funct = 6'h25; issue(s);
    s.funct = 6'h22; issue(s);
    s.funct = 6'h2A; issue(s);
    s.funct = 6'h00; issue(s);
    s.valid = 0;     issue(s);

    // Immediates: sign-extended for ADD class, zero-extended for OR class
    s = base_stim(); s.src = 1; s.imm = 16'hFFFC; s.op = 2'b00; issue(s);
    s.op = 2'b11; issue(s);

    // Forwarding with rs=rt=5
    s = base_stim(); s.rs = 5; s.rt = 5; s.rsd = 32'h44444444; s.rtd = 32'h44444444;
    s.xw = 1; s.xrd = 5; s.xres = 32'h88888888;
    s.ww = 1; s.wrd = 5; s.wres = 32'h99999999;
    issue(s);
    s.xw = 0; issue(s);
    s.xw = 1; s.xrd = 0; s.xres = 32'h12345678;
    s.wrd = 0; s.wres = 32'h12345678; issue(s);

    // Load rs=rt=5, then stall 3 cycles with changing ID inputs and EX/MEM result
    s = base_stim(); s.rs = 5; s.rt = 5; s.rsd = 32'h44444444; s.rtd = 32'h55555555;
    issue(s);
    for (int i = 0; i < 3; i++) begin
      s.stall = 1; s.rsd = $urandom; s.funct = 6'h22; s.rs = 6; s.rd = 9;
      s.xw = 1; s.xrd = 5; s.xres = 32'hA0000000 + 32'(i);
      issue(s);
    end
    // Stall and flush together: flush wins
    s.flush = 1; issue(s);

    // Randomized traffic
    for (int i = 0; i < 400; i++) issue(rand_stim());

    // Asynchronous reset mid-cycle while a valid instruction sits in EX, during a stall
    s = base_stim(); s.rsd = 32'h11; s.rtd = 32'h22; s.rw = 1; s.mr = 1;
    issue(s);
    @(posedge clk);
    #3;
    stall_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ops", 128'(ops_act), 128'd0);
    chk("async_rst_ctl", 128'(ctl_act), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model = empty_ex();

    // Restart after reset
    for (int i = 0; i < 20; i++) issue(rand_stim());
    @(posedge clk);
    #3;
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
